// File: rtl/rw_port_ram_be_pkg.sv
// Shared constants and types for the byte-enable read/write-port RAM.
// Holds forwarding modes, clear FSM encoding and lane-count helper.
package rw_port_ram_be_pkg;

   localparam int BYPASS_OLD = 0;
   localparam int BYPASS_FWD = 1;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   function automatic int lane_count(input int dw, input int bw);
      return dw / bw;
   endfunction

endpackage

// File: rtl/rw_port_ram_be_core.sv
// Bare byte-lane-write array with registered read port.
// No reset so synthesis can map it onto block RAM.
module rw_port_ram_be_core
   import rw_port_ram_be_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                                             clk,
   input  logic [ADDR_WIDTH-1:0]                            addr_r,
   input  logic                                             re,
   input  logic [ADDR_WIDTH-1:0]                            addr_w,
   input  logic [DATA_WIDTH-1:0]                            data_in,
   input  logic                                             we,
   input  logic [lane_count(DATA_WIDTH, BYTE_WIDTH)-1:0]    be,
   output logic [DATA_WIDTH-1:0]                            data_out
);

   localparam int NB = lane_count(DATA_WIDTH, BYTE_WIDTH);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
               mem[addr_w][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                  data_in[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
      if (re) begin
         data_out <= mem[addr_r];
      end
   end

endmodule

// File: rtl/rw_port_ram_be.sv
// Byte-enable simple dual-port RAM with clear sequencer,
// optional write forwarding and optional output register.
module rw_port_ram_be
   import rw_port_ram_be_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 10,
   parameter int BYTE_WIDTH     = 8,
   parameter int OUT_REG        = 0,
   parameter int BYPASS         = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                                             clk,
   input  logic                                             reset_n,
   input  logic [ADDR_WIDTH-1:0]                            addr_r,
   input  logic                                             re,
   input  logic [ADDR_WIDTH-1:0]                            addr_w,
   input  logic [DATA_WIDTH-1:0]                            data_in,
   input  logic                                             we,
   input  logic [lane_count(DATA_WIDTH, BYTE_WIDTH)-1:0]    be,
   output logic [DATA_WIDTH-1:0]                            data_out,
   output logic                                             valid_out,
   output logic                                             busy
);

   localparam int NB = lane_count(DATA_WIDTH, BYTE_WIDTH);

   if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
      $fatal(1, "DATA_WIDTH must be a multiple of BYTE_WIDTH");
   end

   state_t                state;
   state_t                state_nx;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  clearing;
   logic                  accept;

   logic                  m_we;
   logic                  m_re;
   logic [NB-1:0]         m_be;
   logic [ADDR_WIDTH-1:0] m_addr_w;
   logic [DATA_WIDTH-1:0] m_din;
   logic [DATA_WIDTH-1:0] m_q;

   logic [NB-1:0]         fwd_mask;
   logic [DATA_WIDTH-1:0] fwd_data;
   logic                  have;
   logic                  v1;
   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] stage1;
   logic                  vq;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         clr_cnt <= '0;
      end else if (state == ST_CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_CLEAR: if (clr_cnt == '1) state_nx = ST_READY;
         ST_READY: state_nx = ST_READY;
         default:  state_nx = ST_READY;
      endcase
   end

   always_comb begin
      busy     = (state == ST_CLEAR);
      clearing = busy & reset_n;
      accept   = reset_n & ~busy;
   end

   always_comb begin
      m_we     = we & accept & (|be);
      m_be     = be;
      m_addr_w = addr_w;
      m_din    = data_in;
      if (clearing) begin
         m_we     = 1'b1;
         m_be     = '1;
         m_addr_w = clr_cnt;
         m_din    = '0;
      end
      m_re = re & accept;
   end

   rw_port_ram_be_core #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH)
   ) u_core (
      .clk      (clk),
      .addr_r   (addr_r),
      .re       (m_re),
      .addr_w   (m_addr_w),
      .data_in  (m_din),
      .we       (m_we),
      .be       (m_be),
      .data_out (m_q)
   );

   // Forward mask travels with the read so the merge sees the same cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fwd_mask <= '0;
         fwd_data <= '0;
         have     <= 1'b0;
         v1       <= 1'b0;
      end else begin
         v1 <= m_re;
         if (m_re) begin
            have     <= 1'b1;
            fwd_data <= data_in;
            if (BYPASS == BYPASS_FWD && we && addr_r == addr_w) begin
               fwd_mask <= be;
            end else begin
               fwd_mask <= '0;
            end
         end
      end
   end

   always_comb begin
      merged = m_q;
      for (int i = 0; i < NB; i++) begin
         if (fwd_mask[i]) begin
            merged[i*BYTE_WIDTH +: BYTE_WIDTH] =
               fwd_data[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
      stage1 = merged & {DATA_WIDTH{have}};
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q2;
      logic                  v2;
      always_ff @(posedge clk) begin
         if (!reset_n) begin
            q2 <= '0;
            v2 <= 1'b0;
         end else begin
            v2 <= v1;
            if (v1) q2 <= stage1;
         end
      end
      assign data_out = q2;
      assign vq       = v2;
   end else begin : g_no_out_reg
      assign data_out = stage1;
      assign vq       = v1;
   end

   assign valid_out = vq & ~busy;

endmodule

// File: tb/tb_rw_port_ram_be.sv
// Scoreboard bench driving three RAM configurations in lockstep.
// Each read pushes its expected word and due cycle per instance.
module tb_rw_port_ram_be;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int NB = 4;
   localparam int LAT [3] = '{1, 2, 1};
   localparam int BYP [3] = '{0, 1, 1};

   typedef struct {
      int          k;
      int          due;
      logic [31:0] d;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] addr_r;
   logic          re;
   logic [AW-1:0] addr_w;
   logic [DW-1:0] data_in;
   logic          we;
   logic [NB-1:0] be;
   logic [DW-1:0] dout [3];
   logic          vout [3];
   logic          bsy  [3];

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   bit          mon_en = 1'b0;
   bit          mbusy [3];
   logic [31:0] mem [3][16];
   logic [31:0] last_exp [3];
   exp_t        sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rw_port_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
      .OUT_REG(0), .BYPASS(0), .CLEAR_ON_RESET(1)) u_d0 (
      .clk(clk), .reset_n(reset_n), .addr_r(addr_r), .re(re),
      .addr_w(addr_w), .data_in(data_in), .we(we), .be(be),
      .data_out(dout[0]), .valid_out(vout[0]), .busy(bsy[0]));

   rw_port_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
      .OUT_REG(1), .BYPASS(1), .CLEAR_ON_RESET(1)) u_d1 (
      .clk(clk), .reset_n(reset_n), .addr_r(addr_r), .re(re),
      .addr_w(addr_w), .data_in(data_in), .we(we), .be(be),
      .data_out(dout[1]), .valid_out(vout[1]), .busy(bsy[1]));

   rw_port_ram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
      .OUT_REG(0), .BYPASS(1), .CLEAR_ON_RESET(0)) u_d2 (
      .clk(clk), .reset_n(reset_n), .addr_r(addr_r), .re(re),
      .addr_w(addr_w), .data_in(data_in), .we(we), .be(be),
      .data_out(dout[2]), .valid_out(vout[2]), .busy(bsy[2]));

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic chk_busy(input logic b0, input logic b1, input logic b2);
      check("busy0", {31'b0, bsy[0]}, {31'b0, b0});
      check("busy1", {31'b0, bsy[1]}, {31'b0, b1});
      check("busy2", {31'b0, bsy[2]}, {31'b0, b2});
   endtask

   // Per-cycle monitor: a read due now must be valid with the queued
   // word; otherwise valid must be low and data must hold.
   always @(negedge clk) begin
      logic        hit [3];
      logic [31:0] ev  [3];
      if (mon_en) begin
         for (int k = 0; k < 3; k++) begin
            hit[k] = 1'b0;
            ev[k]  = '0;
         end
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
               hit[sb[i].k] = 1'b1;
               ev[sb[i].k]  = sb[i].d;
               sb.delete(i);
            end
         end
         for (int k = 0; k < 3; k++) begin
            if (hit[k]) last_exp[k] = ev[k];
            check($sformatf("valid%0d@%0d", k, cyc), {31'b0, vout[k]},
                  {31'b0, hit[k]});
            check($sformatf("data%0d@%0d", k, cyc), dout[k], last_exp[k]);
         end
      end
   end

   task automatic op(input logic r, input logic [3:0] ra, input logic w,
                     input logic [3:0] wa, input logic [31:0] d,
                     input logic [3:0] b);
      exp_t e;
      re = r; addr_r = ra; we = w; addr_w = wa; data_in = d; be = b;
      if (reset_n) begin
         for (int k = 0; k < 3; k++) begin
            if (!mbusy[k]) begin
               if (r) begin
                  e.k   = k;
                  e.due = cyc + LAT[k];
                  e.d   = mem[k][ra];
                  if (BYP[k] == 1 && w && ra == wa) begin
                     for (int j = 0; j < NB; j++)
                        if (b[j]) e.d[j*8 +: 8] = d[j*8 +: 8];
                  end
                  sb.push_back(e);
               end
               if (w) begin
                  for (int j = 0; j < NB; j++)
                     if (b[j]) mem[k][wa][j*8 +: 8] = d[j*8 +: 8];
               end
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) op(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      re = 0; we = 0; addr_r = 0; addr_w = 0; data_in = 0; be = 0;
      for (int k = 0; k < 3; k++) begin
         last_exp[k] = '0;
         for (int a = 0; a < 16; a++) mem[k][a] = 'x;
      end
      mbusy[0] = 1; mbusy[1] = 1; mbusy[2] = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_busy(1, 1, 0);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_data%0d", k), dout[k], 32'h0);
         check($sformatf("rst_valid%0d", k), {31'b0, vout[k]}, 32'h0);
      end
      mon_en = 1'b1;

      // Partial sweep, then reset at clear count 7 restarts it.
      reset_n = 1'b1;
      for (int i = 0; i < 7; i++) begin
         chk_busy(1, 1, 0);
         op(0, 0, 1, i[3:0], 32'hDEAD0000 | i, 4'hF);
      end
      reset_n = 1'b0;
      we = 0; re = 0;
      @(posedge clk);
      for (int k = 0; k < 3; k++) last_exp[k] = '0;
      @(negedge clk);
      chk_busy(1, 1, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk_busy(1, 1, 0);
         op(0, 0, 1, i[3:0], 32'hBEEF0000 | i, 4'hF);
      end
      chk_busy(0, 0, 0);
      mbusy[0] = 0; mbusy[1] = 0;
      for (int a = 0; a < 16; a++) begin
         mem[0][a] = '0;
         mem[1][a] = '0;
      end

      for (int i = 0; i < 16; i++) op(1, i[3:0], 0, 0, 0, 0);
      idle(3);

      op(0, 0, 1, 5, 32'hAABBCCDD, 4'b1111);
      op(0, 0, 1, 5, 32'h11223344, 4'b0101);
      op(1, 5, 0, 0, 0, 0);
      op(0, 0, 1, 6, 32'h55555555, 4'b0000);
      op(1, 6, 0, 0, 0, 0);
      idle(2);

      op(0, 0, 1, 3, 32'h01020304, 4'hF);
      op(1, 3, 1, 3, 32'hF0F0F0F0, 4'b0011);
      op(1, 3, 0, 0, 0, 0);
      op(1, 5, 1, 6, 32'h77777777, 4'hF);
      op(1, 6, 0, 0, 0, 0);
      idle(2);

      for (int i = 0; i < 4; i++) op(0, 0, 1, i[3:0], 10 + i, 4'hF);
      for (int i = 0; i < 4; i++) op(1, i[3:0], 0, 0, 0, 0);
      idle(3);
      op(1, 2, 0, 0, 0, 0);
      idle(3);

      for (int n = 0; n < 300; n++) begin
         op($urandom_range(0, 1), 4'($urandom_range(0, 15)),
            $urandom_range(0, 1), 4'($urandom_range(0, 15)),
            $urandom, 4'($urandom_range(0, 15)));
      end
      idle(4);
      check("sb_empty", sb.size(), 0);
      mon_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rw_port_ram_be.md
# rw_port_ram_be

Parametrised simple dual-port RAM (one read port, one write port, one clock) with per-byte write enables, optional read-during-write forwarding, optional output pipeline register, and an optional hardware clear sequencer that zeroes the array after reset. It is the general-purpose on-chip memory for register files, scratchpads and FIFO storage in the mini16 system, replacing the fixed-behaviour read/write-port RAM wherever byte writes, determinate power-up contents or a registered output are required.

## Interface
- DATA_WIDTH, 32: word width; must be a multiple of BYTE_WIDTH
- ADDR_WIDTH, 10: depth = 2^ADDR_WIDTH words
- BYTE_WIDTH, 8: bits per write-enable lane; lanes NB = DATA_WIDTH/BYTE_WIDTH
- OUT_REG, 0: 1 adds one output register stage (read latency 2)
- BYPASS, 0: 0 = read-old-data on same-address collision; 1 = forward written bytes
- CLEAR_ON_RESET, 1: 1 = zero every word after reset before accepting traffic
- clk  in  1  sole clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- addr_r  in  ADDR_WIDTH  read address
- re  in  1  read enable
- addr_w  in  ADDR_WIDTH  write address
- data_in  in  DATA_WIDTH  write data
- we  in  1  write enable
- be  in  NB  byte-lane enables; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH]
- data_out  out  DATA_WIDTH  read data
- valid_out  out  1  data_out carries the result of a read this cycle
- busy  out  1  clear sequence in progress; all requests ignored

## Operation
- Reset (reset_n=0 at a clock edge): data_out=0, valid_out=0, pipeline registers cleared, clear counter=0; busy=1 if CLEAR_ON_RESET else 0. Array contents untouched by reset itself.
- FSM states CLEAR, READY. Reset enters CLEAR if CLEAR_ON_RESET, else READY.
- CLEAR: each cycle write all-zero word to address = counter, counter+1; after writing address 2^ADDR_WIDTH-1 move to READY. busy=1 throughout CLEAR. re/we/be ignored; valid_out=0.
- Reset asserted mid-CLEAR restarts sweep at address 0.
- READY: write when we=1, only lanes with be[i]=1 updated; we=1 with be=0 is a no-op. Read when re=1.
- re=0: memory read register holds; data_out holds last value; valid_out=0.
- Collision (re & we & addr_r==addr_w, READY):
  - BYPASS=0: returns pre-write word.
  - BYPASS=1: lanes with be[i]=1 return data_in lane, others pre-write content. Forward mask and data registered alongside read, merged at first output stage.
- Collision with different addresses: independent, no interaction.
- Out-of-range not possible (full decode).

## Timing
- Read latency L = 1 + OUT_REG cycles from re-sampled edge to data_out/valid_out.
- Throughput: one read and one write per cycle in READY.
- Write visible to a non-colliding read issued the next cycle.
- Clear duration: exactly 2^ADDR_WIDTH cycles from first edge with reset_n=1; busy falls on the edge after the last clear write; first accepted request is in the cycle busy=0 is observed.
- valid_out is re delayed by L, forced 0 while busy and for L cycles after reset.

## Structure
- Shared package/header: BYPASS_OLD=0 / BYPASS_FWD=1 constants, FSM state encodings (CLEAR, READY), NB derivation.
- Sub-module rw_port_ram_be_core: bare byte-lane-write array with registered read (no reset, inferable as block RAM). Top holds clear FSM, write mux (clear vs. user), forwarding merge, OUT_REG stage, valid pipeline.
- Elaboration check: DATA_WIDTH % BYTE_WIDTH != 0 is a fatal error.

## Test plan
- Clear: ADDR_WIDTH=4, CLEAR_ON_RESET=1; release reset -> busy=1 for 16 cycles, then 0; read all 16 addresses -> 0x00000000, valid_out after L cycles each.
- Byte write: write 0xAABBCCDD be=1111 to addr 5, then 0x11223344 be=0101 -> read addr 5 = 0xAA22CC44.
- Collision BYPASS=0 vs 1: addr 3 holds 0x01020304; same-cycle read+write 0xF0F0F0F0 be=0011 -> BYPASS=0 returns 0x01020304, BYPASS=1 returns 0x0102F0F0; next read 0x0102F0F0 in both.
- Latency/valid: OUT_REG=1, back-to-back re on addrs 0..3 holding 10,11,12,13 -> data_out 10..13 on cycles 2..5, valid_out high exactly those cycles; re=0 gap -> data_out held, valid_out=0.
- Reset mid-clear: assert reset_n=0 at clear count 7 for one cycle -> busy stays 1 a full 16 cycles after release; we pulses during busy leave memory all zero.
- No-clear mode: CLEAR_ON_RESET=0 -> busy=0 first cycle after reset; write/read addr 0 works immediately, data_out=0 until first read returns.
